// File: rtl/pipe_hazard_ctl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_hazard_ctl_if : hazard-controller pipeline/bus bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface pipe_hazard_ctl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic [4:0]       ex_rs1;
  logic [4:0]       ex_rs2;
  logic [4:0]       ex_rd;
  logic             ex_RegWEn;
  logic             ex_is_load;
  logic             ex_pc_sel;
  logic [4:0]       mem_rd;
  logic             mem_RegWEn;
  logic [4:0]       wb_rd;
  logic             wb_RegWEn;
  logic             dmem_req;
  logic             dmem_rdy;
  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             mem_wb_flush;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             bus_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    output ex_rs1, ex_rs2, ex_rd, ex_RegWEn, ex_is_load, ex_pc_sel,
    output mem_rd, mem_RegWEn, wb_rd, wb_RegWEn, dmem_req, dmem_rdy,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    input  if_id_flush, id_ex_flush, mem_wb_flush,
    input  fwd_a, fwd_b, bus_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    input  ex_rs1, ex_rs2, ex_rd, ex_RegWEn, ex_is_load, ex_pc_sel,
    input  mem_rd, mem_RegWEn, wb_rd, wb_RegWEn, dmem_req, dmem_rdy,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    output if_id_flush, id_ex_flush, mem_wb_flush,
    output fwd_a, fwd_b, bus_err, stall_cnt, flush_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_hazard_ctl : stall/flush/forwarding controller for the 5-stage rv32 pipe
// Rev 1.0
// ---------------------------------------------------------------------------
module pipe_hazard_ctl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  pipe_hazard_ctl_if.slave hz
);

  localparam int REM_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [REM_W-1:0] REM_LOAD = REM_W'(FLUSH_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             bus_err_q, bus_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic memstall, redirect, loaduse;
  logic freeze, run_eval, redirect_taken;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, mem_wb_flush;
  logic [1:0] fwd_a, fwd_b;

  assign memstall = hz.dmem_req & ~hz.dmem_rdy;
  assign redirect = hz.ex_pc_sel;
  assign loaduse  = hz.ex_is_load & hz.ex_RegWEn & (hz.ex_rd != 5'd0) &
                    ((hz.id_uses_rs1 & (hz.id_rs1 == hz.ex_rd)) |
                     (hz.id_uses_rs2 & (hz.id_rs2 == hz.ex_rd)));

  always_comb begin
    state_d        = state_q;
    rem_d          = rem_q;
    tmo_d          = tmo_q;
    bus_err_d      = bus_err_q;
    freeze         = 1'b0;
    run_eval       = 1'b0;
    redirect_taken = 1'b0;
    pc_en          = 1'b1;
    if_id_en       = 1'b1;
    id_ex_en       = 1'b1;
    ex_mem_en      = 1'b1;
    mem_wb_en      = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    mem_wb_flush   = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (memstall) begin
          freeze  = 1'b1;
          tmo_d   = TMO_W'(1);
          state_d = ST_MEM_WAIT;
        end else begin
          run_eval = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        // A dropped request also releases, so the freeze cannot outlive the access.
        if (!memstall) begin
          run_eval = 1'b1;
        end else if (tmo_q == TMO_MAX) begin
          bus_err_d = 1'b1;
          run_eval  = 1'b1;
        end else begin
          freeze = 1'b1;
          tmo_d  = tmo_q + 1'b1;
        end
      end
      ST_FLUSH: begin
        if (memstall) begin
          freeze  = 1'b1;
          tmo_d   = TMO_W'(1);
          state_d = ST_MEM_WAIT;
        end else if (redirect) begin
          run_eval = 1'b1;
        end else begin
          if_id_flush = 1'b1;
          rem_d       = rem_q - 1'b1;
          state_d     = (rem_q == REM_W'(1)) ? ST_RUN : ST_FLUSH;
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (freeze) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end

    // Normal evaluation; a flush interrupted by a memory wait resumes via rem_q.
    if (run_eval) begin
      if (redirect) begin
        if_id_flush    = 1'b1;
        id_ex_flush    = 1'b1;
        redirect_taken = 1'b1;
        rem_d          = REM_LOAD;
        state_d        = (REM_LOAD != '0) ? ST_FLUSH : ST_RUN;
      end else begin
        if (loaduse) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end
        state_d = (rem_q != '0) ? ST_FLUSH : ST_RUN;
      end
    end

    if (!rst_n) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_en && stall_cnt_q != CNT_SAT) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (redirect_taken && flush_cnt_q != CNT_SAT) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (rst_n) begin
      if (hz.mem_RegWEn && hz.mem_rd != 5'd0 && hz.mem_rd == hz.ex_rs1) begin
        fwd_a = 2'b01;
      end else if (hz.wb_RegWEn && hz.wb_rd != 5'd0 && hz.wb_rd == hz.ex_rs1) begin
        fwd_a = 2'b10;
      end
      if (hz.mem_RegWEn && hz.mem_rd != 5'd0 && hz.mem_rd == hz.ex_rs2) begin
        fwd_b = 2'b01;
      end else if (hz.wb_RegWEn && hz.wb_rd != 5'd0 && hz.wb_rd == hz.ex_rs2) begin
        fwd_b = 2'b10;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      rem_q       <= '0;
      tmo_q       <= '0;
      bus_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      tmo_q       <= tmo_d;
      bus_err_q   <= bus_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.pc_en        = pc_en;
  assign hz.if_id_en     = if_id_en;
  assign hz.id_ex_en     = id_ex_en;
  assign hz.ex_mem_en    = ex_mem_en;
  assign hz.mem_wb_en    = mem_wb_en;
  assign hz.if_id_flush  = if_id_flush;
  assign hz.id_ex_flush  = id_ex_flush;
  assign hz.mem_wb_flush = mem_wb_flush;
  assign hz.fwd_a        = fwd_a;
  assign hz.fwd_b        = fwd_b;
  assign hz.bus_err      = bus_err_q;
  assign hz.stall_cnt    = stall_cnt_q;
  assign hz.flush_cnt    = flush_cnt_q;

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctl.md
Name: pipe_hazard_ctl

Overview:
- Central stall/flush/forwarding controller for the 5-stage rv32 pipeline (IF, ID, EX, MEM, WB).
- Consumes decoded register indices and control bits (RegWEn, load flag, pc_sel) from the ID/EX/MEM/WB pipeline registers, plus the data-memory handshake.
- Drives per-stage register enables, bubble/flush controls and EX operand forwarding selects.
- Sequences multi-cycle events: load-use stall, branch/jump redirect penalty, data-memory wait with timeout. Keeps saturating stall/flush performance counters.

Parameters:
FLUSH_CYCLES, 2, bubble cycles injected into IF/ID after a taken redirect (>=1)
MEM_TIMEOUT, 255, max cycles in MEM_WAIT before bus error (>=1)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
id_rs1  in  5  rs1 index of instruction in ID
id_rs2  in  5  rs2 index of instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_rs1  in  5  rs1 index of instruction in EX
ex_rs2  in  5  rs2 index of instruction in EX
ex_rd  in  5  destination of instruction in EX
ex_RegWEn  in  1  EX instruction writes rd
ex_is_load  in  1  EX instruction is a load
ex_pc_sel  in  1  EX resolved a taken branch/jump (redirect)
mem_rd  in  5  destination of instruction in MEM
mem_RegWEn  in  1  MEM instruction writes rd
wb_rd  in  5  destination of instruction in WB
wb_RegWEn  in  1  WB instruction writes rd
dmem_req  in  1  MEM stage issuing data access
dmem_rdy  in  1  data memory completes access this cycle
pc_en  out  1  PC register load enable
if_id_en  out  1  IF/ID register enable
id_ex_en  out  1  ID/EX register enable
ex_mem_en  out  1  EX/MEM register enable
mem_wb_en  out  1  MEM/WB register enable
if_id_flush  out  1  load bubble into IF/ID
id_ex_flush  out  1  load bubble into ID/EX
mem_wb_flush  out  1  load bubble into MEM/WB
fwd_a  out  2  EX operand A select: 00 regfile, 01 MEM result, 10 WB result
fwd_b  out  2  EX operand B select, same encoding
bus_err  out  1  sticky: MEM_WAIT timed out
stall_cnt  out  CNT_W  cycles with pc_en=0, saturating
flush_cnt  out  CNT_W  redirects taken, saturating

Behaviour:
- States: RUN, MEM_WAIT, FLUSH. Registered: state, flush counter, timeout counter, bus_err, stall_cnt, flush_cnt. All other outputs combinational from state and inputs.
- Reset (rst_n=0 at edge): state=RUN, counters=0, bus_err=0. While rst_n=0: all *_en=0, all *_flush=1, fwd_a=fwd_b=00.
- Hazard terms (rd==0 never matches):
  - memstall = dmem_req & ~dmem_rdy
  - redirect = ex_pc_sel
  - loaduse = ex_is_load & ex_RegWEn & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd))
- Priority: memstall > redirect > loaduse.
- RUN, no hazard: all enables 1, flushes 0.
- RUN with memstall: pc_en, if_id_en, id_ex_en, ex_mem_en = 0; mem_wb_en=1, mem_wb_flush=1; timeout counter loads 1; go MEM_WAIT. A pending redirect or loaduse is held and re-evaluated on release.
- RUN with redirect: all enables 1, if_id_flush=1, id_ex_flush=1, flush_cnt+1. If FLUSH_CYCLES>1, go FLUSH with remaining=FLUSH_CYCLES-1.
- RUN with loaduse: pc_en=0, if_id_en=0, id_ex_flush=1, others enabled. Exactly 1 stall cycle; no state change. Redirect in same cycle wins, with no stall.
- MEM_WAIT: same freeze as memstall entry. On dmem_rdy=1, release this cycle with normal RUN evaluation (redirect/loaduse still apply); go RUN.
  - Else, if timeout counter == MEM_TIMEOUT: set bus_err, force release as if dmem_rdy, go RUN. Otherwise increment.
- FLUSH: if_id_flush=1, all enables 1, decrement remaining; go RUN when remaining reaches 0.
  - memstall in FLUSH takes MEM_WAIT priority, and the remaining count is preserved: return to FLUSH if it is nonzero.
  - A redirect in FLUSH reloads remaining=FLUSH_CYCLES-1 and increments flush_cnt.
- Forwarding, per operand:
  - 01 if mem_RegWEn & mem_rd!=0 & mem_rd==ex_rsX
  - else 10 if wb_RegWEn & wb_rd!=0 & wb_rd==ex_rsX
  - else 00
  - Forwarding is independent of stalls.
- stall_cnt increments every non-reset cycle with pc_en=0. Both counters saturate at all-ones.
- Reset mid-stall/flush: returns to RUN next cycle; counters and bus_err cleared.

Test Plan:
- Load-use: ex_is_load=1, ex_RegWEn=1, ex_rd=5, id_uses_rs1=1, id_rs1=5 -> 1 cycle of pc_en=0, if_id_en=0, id_ex_flush=1, stall_cnt=1; ex_rd=0 -> no stall.
- Redirect, FLUSH_CYCLES=2: ex_pc_sel pulse -> cycle0: if_id_flush=id_ex_flush=1; cycle1: if_id_flush=1 only; cycle2: RUN; flush_cnt=1.
- Memory wait: dmem_req=1, dmem_rdy low for 3 cycles -> front 4 enables low and mem_wb_flush=1 for 3 cycles, release on 4th; stall_cnt=3.
- Timeout, MEM_TIMEOUT=4: dmem_rdy held 0 -> release after 4 wait cycles, bus_err=1 sticky until rst_n=0.
- Forwarding: ex_rs1=3, mem_rd=3, wb_rd=3, both RegWEn=1 -> fwd_a=01; mem_RegWEn=0 -> fwd_a=10; ex_rs2=0, wb_rd=0 -> fwd_b=00.
- Simultaneous events: memstall+redirect -> freeze, then redirect flush on release. Loaduse+redirect -> flush, no stall. Reset during FLUSH -> RUN, counters 0.
